// File: rtl/serial_adder.sv
// Digit-serial adder: DIGIT bits per cycle over WIDTH/DIGIT RUN cycles, result published on entry to DONE.
// Optional macro SERIAL_ADDER_SUB_EN adds a `sub` input for a-b computed as a+~b+1.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] b_in;
    logic             c_in;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    // Ripple chain across one digit; chain[DIGIT-1] is the carry into the current top bit.
    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] digit_sum;

    assign chain[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_digit
            assign digit_sum[gi] = a_reg[gi] ^ b_reg[gi] ^ chain[gi];
            assign chain[gi+1]   = (a_reg[gi] & b_reg[gi]) | (chain[gi] & (a_reg[gi] ^ b_reg[gi]));
        end
    endgenerate

    // New digit enters at the top; after NDIG shifts digit 0 sits at the LSB.
    logic [WIDTH-1:0] res_shift;

    generate
        if (DIGIT == WIDTH) begin : g_single
            assign res_shift = digit_sum;
        end else begin : g_multi
            assign res_shift = {digit_sum, res_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

    logic last_digit;
    assign last_digit = (cnt_reg == CW'(NDIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            res_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b_in;
                        carry_reg <= c_in;
                        cnt_reg   <= '0;
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_reg     <= a_reg >> DIGIT;
                    b_reg     <= b_reg >> DIGIT;
                    carry_reg <= chain[DIGIT];
                    res_reg   <= res_shift;
                    if (last_digit) begin
                        sum_reg   <= res_shift;
                        cout_reg  <= chain[DIGIT];
                        ovf_reg   <= chain[DIGIT] ^ chain[DIGIT-1];
                        cnt_reg   <= '0;
                        state_reg <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg != S_IDLE);
    assign done = (state_reg == S_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule
